// File: rtl/crc_if.sv
// Beat/result bus between a frame source and the CRC engine.
// The slave modport is the engine side; the master modport is the driver side.
interface crc_if #(
    parameter int CRC_W  = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
);
    logic              cfg_check;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_sof;
    logic              s_eof;
    logic              abort;
    logic              res_valid;
    logic              res_ready;
    logic [CRC_W-1:0]  res_crc;
    logic              res_ok;
    logic [LEN_W-1:0]  res_len;
    logic              res_restart;

    modport slave (
        input  cfg_check, s_valid, s_data, s_sof, s_eof, abort, res_ready,
        output s_ready, res_valid, res_crc, res_ok, res_len, res_restart
    );

    modport master (
        output cfg_check, s_valid, s_data, s_sof, s_eof, abort, res_ready,
        input  s_ready, res_valid, res_crc, res_ok, res_len, res_restart
    );
endinterface

// File: rtl/crc_engine.sv
// Frame-based CRC generator/checker: MSB-first bit-serial CRC folded into one beat per cycle,
// with a held result that must be acknowledged before the next frame is accepted.
module crc_engine #(
    parameter int               CRC_W  = 8,
    parameter int               DATA_W = 8,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(8'h2F),
    parameter logic [CRC_W-1:0] INIT   = '1,
    parameter int               LEN_W  = 16
) (
    input logic  clk,
    input logic  rst,
    crc_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               restart_q, restart_d;
    logic               check_q, check_d;
    logic               accept;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc_in,
                                                  input logic [DATA_W-1:0] data);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ data[i];
            c  = (c << 1) ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            len_q     <= '0;
            restart_q <= 1'b0;
            check_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            len_q     <= len_d;
            restart_q <= restart_d;
            check_q   <= check_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        len_d     = len_q;
        restart_d = restart_q;
        check_d   = check_q;
        accept    = bus.s_valid && (state_q != DONE);
        case (state_q)
            IDLE: begin
                if (accept && bus.s_sof) begin
                    crc_d     = crc_step(INIT, bus.s_data);
                    len_d     = LEN_W'(1);
                    restart_d = 1'b0;
                    check_d   = bus.cfg_check;
                    state_d   = bus.s_eof ? DONE : RUN;
                end
            end
            RUN: begin
                // Abort takes priority over a beat offered in the same cycle.
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (bus.s_sof) begin
                        crc_d     = crc_step(INIT, bus.s_data);
                        len_d     = LEN_W'(1);
                        restart_d = 1'b1;
                    end else begin
                        crc_d = crc_step(crc_q, bus.s_data);
                        len_d = (len_q == '1) ? len_q : len_q + LEN_W'(1);
                    end
                    if (bus.s_eof) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.s_ready     = (state_q != DONE);
        bus.res_valid   = (state_q == DONE);
        bus.res_crc     = crc_q;
        bus.res_ok      = (state_q == DONE) && (!check_q || (crc_q == '0));
        bus.res_len     = len_q;
        bus.res_restart = restart_q;
    end

endmodule

// File: tb/tb_crc_engine.sv
// Scoreboard bench for crc_engine at default parameters: expected results are queued as
// frames are driven and compared when the engine presents a consumed result.
module tb_crc_engine;

    typedef struct packed {
        logic [7:0]  crc;
        logic        ok;
        logic [15:0] len;
        logic        restart;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   check_count = 0;
    int   pass_count  = 0;
    exp_t sb_q[$];

    crc_if #(.CRC_W(8), .DATA_W(8), .LEN_W(16)) bus ();

    crc_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_crc(input logic [7:0] msg[$]);
        logic [7:0] c;
        c = 8'hFF;
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) begin
                if (c[7] ^ msg[i][b]) c = (c << 1) ^ 8'h2F;
                else                  c = c << 1;
            end
        end
        return c;
    endfunction

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.s_valid   = 1'b0;
        bus.s_sof     = 1'b0;
        bus.s_eof     = 1'b0;
        bus.s_data    = 8'h00;
        bus.abort     = 1'b0;
    endtask

    // Offers one beat and waits (bounded) for the engine to take it.
    task automatic applyStimulus(input logic [7:0] d, input logic sof, input logic eof,
                                 input logic chk);
        logic accepted;
        accepted      = 1'b0;
        bus.s_valid   = 1'b1;
        bus.s_data    = d;
        bus.s_sof     = sof;
        bus.s_eof     = eof;
        bus.cfg_check = chk;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                accepted = 1'b1;
                break;
            end
            sync();
        end
        sync();
        clear_inputs();
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] msg[$], input logic chk);
        for (int i = 0; i < msg.size(); i++) begin
            applyStimulus(msg[i], i == 0, i == msg.size() - 1, chk);
        end
        @(negedge clk);
        checkOutput("latency_res_valid", {31'd0, bus.res_valid}, 32'd1);
        sync();
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_res_valid"},   {31'd0, bus.res_valid},   32'd0);
        checkOutput({tag, "_res_crc"},     {24'd0, bus.res_crc},     32'hFF);
        checkOutput({tag, "_res_ok"},      {31'd0, bus.res_ok},      32'd0);
        checkOutput({tag, "_res_len"},     {16'd0, bus.res_len},     32'd0);
        checkOutput({tag, "_res_restart"}, {31'd0, bus.res_restart}, 32'd0);
    endtask

    // Pops and compares whenever a result is on the bus and is being consumed.
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("res_crc",     {24'd0, bus.res_crc},     {24'd0, e.crc});
                checkOutput("res_ok",      {31'd0, bus.res_ok},      {31'd0, e.ok});
                checkOutput("res_len",     {16'd0, bus.res_len},     {16'd0, e.len});
                checkOutput("res_restart", {31'd0, bus.res_restart}, {31'd0, e.restart});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] msg[$];
        logic [7:0] exp_crc;

        clear_inputs();
        bus.cfg_check = 1'b0;
        bus.res_ready = 1'b1;

        @(negedge clk);
        check_reset_outputs("reset");
        sync();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", {31'd0, bus.s_ready}, 32'd1);
        sync();

        // Generate mode, single beat
        sb_q.push_back('{crc: 8'h42, ok: 1'b1, len: 16'd1, restart: 1'b0});
        msg = '{8'h00};
        send_frame(msg, 1'b0);

        // Check mode, good and corrupted residues
        sb_q.push_back('{crc: 8'h00, ok: 1'b1, len: 16'd2, restart: 1'b0});
        msg = '{8'h00, 8'h42};
        send_frame(msg, 1'b1);
        sb_q.push_back('{crc: 8'h2F, ok: 1'b0, len: 16'd2, restart: 1'b0});
        msg = '{8'h00, 8'h43};
        send_frame(msg, 1'b1);

        // A non-SOF beat in IDLE is swallowed without producing anything
        applyStimulus(8'h77, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("idle_discard_no_result", {31'd0, bus.res_valid}, 32'd0);
        sync();

        // Multi-beat frame from the model, then the same frame checked with its CRC appended
        msg = '{8'h12, 8'h34, 8'hA5, 8'hFF};
        exp_crc = model_crc(msg);
        sb_q.push_back('{crc: exp_crc, ok: 1'b1, len: 16'd4, restart: 1'b0});
        send_frame(msg, 1'b0);
        msg.push_back(exp_crc);
        sb_q.push_back('{crc: 8'h00, ok: 1'b1, len: 16'd5, restart: 1'b0});
        send_frame(msg, 1'b1);

        // Back-pressure on the result
        bus.res_ready = 1'b0;
        msg = '{8'h5A};
        exp_crc = model_crc(msg);
        sb_q.push_back('{crc: exp_crc, ok: 1'b1, len: 16'd1, restart: 1'b0});
        send_frame(msg, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.s_valid = 1'b1;
            bus.s_sof   = 1'b1;
            bus.s_eof   = 1'b1;
            bus.s_data  = 8'h11;
            @(negedge clk);
            checkOutput("stall_res_valid", {31'd0, bus.res_valid}, 32'd1);
            checkOutput("stall_s_ready",   {31'd0, bus.s_ready},   32'd0);
            checkOutput("stall_res_crc",   {24'd0, bus.res_crc},   {24'd0, exp_crc});
            checkOutput("stall_res_len",   {16'd0, bus.res_len},   32'd1);
            sync();
        end
        clear_inputs();
        bus.res_ready = 1'b1;
        sync();
        @(negedge clk);
        checkOutput("idle_after_ack_valid", {31'd0, bus.res_valid}, 32'd0);
        checkOutput("idle_after_ack_ready", {31'd0, bus.s_ready},   32'd1);
        sync();

        // SOF mid-frame restarts the CRC
        sb_q.push_back('{crc: 8'h42, ok: 1'b1, len: 16'd1, restart: 1'b1});
        msg = '{8'hAA, 8'h00};
        applyStimulus(8'hAA, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("restart_latency", {31'd0, bus.res_valid}, 32'd1);
        sync();

        // Abort wins over an EOF beat offered in the same cycle
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h11, 1'b0, 1'b0, 1'b0);
        bus.abort   = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h22;
        bus.s_eof   = 1'b1;
        sync();
        clear_inputs();
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_no_result", {31'd0, bus.res_valid}, 32'd0);
            sync();
        end
        sb_q.push_back('{crc: 8'h42, ok: 1'b1, len: 16'd1, restart: 1'b0});
        msg = '{8'h00};
        send_frame(msg, 1'b0);

        // Reset mid-frame
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h11, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_midframe");
        sync();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_midframe_ready", {31'd0, bus.s_ready}, 32'd1);
        sync();

        // Reset while a result is pending
        bus.res_ready = 1'b0;
        msg = '{8'h33};
        send_frame(msg, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_done");
        sync();
        rst = 1'b0;
        bus.res_ready = 1'b1;
        sync();
        sb_q.push_back('{crc: 8'h42, ok: 1'b1, len: 16'd1, restart: 1'b0});
        msg = '{8'h00};
        send_frame(msg, 1'b0);

        repeat (3) sync();
        checkOutput("scoreboard_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
